// File: rtl/uart_baud_gen_pkg.sv
// Shared constants, divisor struct and reset-divisor calculation for the UART
// baud tick generator.
package uart_pkg;

  localparam int DIV_W_DEF  = 16;
  localparam int FRAC_W_DEF = 4;

  typedef struct packed {
    logic [31:0] div_int;
    logic [31:0] div_frac;
  } baud_div_t;

  // Integer and fractional cycles per oversample tick for a given clock/baud.
  function automatic baud_div_t reset_div(input longint clk_hz, input longint baud,
                                          input longint sample, input int frac_w);
    longint    denom;
    baud_div_t d;
    denom      = baud * sample;
    d.div_int  = 32'(clk_hz / denom);
    d.div_frac = 32'(((clk_hz << frac_w) / denom) % (64'sd1 << frac_w));
    return d;
  endfunction

endpackage

// File: rtl/uart_baud_gen_if.sv
// Divisor programming, resync and strobe signals of the baud tick generator.
interface uart_baud_gen_if
  import uart_pkg::*;
#(
  parameter int DIV_W  = DIV_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
);
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              div_load;
  logic              rx_start;
  logic              tx_start;
  logic              rx_tick;
  logic              rx_sample;
  logic              rx_bit;
  logic              tx_tick;
  logic              tx_bit;

  modport master (
    output div_int, div_frac, div_load, rx_start, tx_start,
    input  rx_tick, rx_sample, rx_bit, tx_tick, tx_bit
  );

  modport slave (
    input  div_int, div_frac, div_load, rx_start, tx_start,
    output rx_tick, rx_sample, rx_bit, tx_tick, tx_bit
  );
endinterface

// File: rtl/uart_baud_gen_channel.sv
// One fractional-divider tick channel with phase counter and bit strobes.
// HALF_START selects RX resync (half period) versus TX resync (full period).
module baud_channel
  import uart_pkg::*;
#(
  parameter int               SAMPLE_RATE = 16,
  parameter int               DIV_W       = DIV_W_DEF,
  parameter int               FRAC_W      = FRAC_W_DEF,
  parameter int               HALF_START  = 0,
  parameter logic [DIV_W-1:0] RESET_CNT   = {DIV_W{1'b1}}
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DIV_W-1:0]  div_i,
  input  logic [FRAC_W-1:0] div_f,
  input  logic              start,
  output logic              tick,
  output logic              sample,
  output logic              bit_strobe
);
  localparam int              PH_W    = $clog2(SAMPLE_RATE);
  localparam logic [PH_W-1:0] PH_MID  = PH_W'(SAMPLE_RATE / 2 - 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SAMPLE_RATE - 1);

  logic [DIV_W-1:0]  cnt_r, cnt_d;
  logic [FRAC_W-1:0] facc_r, facc_d;
  logic [PH_W-1:0]   phase_r, phase_d;
  logic [FRAC_W:0]   sum_s;

  // Strobes come only from registered state so inputs never reach them.
  assign tick       = (cnt_r == {DIV_W{1'b0}});
  assign sample     = (HALF_START != 0) ? (tick & (phase_r == PH_MID)) : 1'b0;
  assign bit_strobe = tick & (phase_r == PH_LAST);

  // Next-state: resync beats reload; carry out of facc stretches the period.
  always_comb begin
    sum_s   = {1'b0, facc_r} + {1'b0, div_f};
    cnt_d   = cnt_r - DIV_W'(1);
    facc_d  = facc_r;
    phase_d = phase_r;
    if (start) begin
      cnt_d   = (HALF_START != 0) ? (div_i >> 1) : (div_i - DIV_W'(1));
      facc_d  = {FRAC_W{1'b0}};
      phase_d = {PH_W{1'b0}};
    end else if (tick) begin
      facc_d  = sum_s[FRAC_W-1:0];
      cnt_d   = sum_s[FRAC_W] ? div_i : (div_i - DIV_W'(1));
      phase_d = phase_r + PH_W'(1);
    end else begin
      cnt_d   = cnt_r - DIV_W'(1);
    end
  end

  // Channel state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_r   <= RESET_CNT;
      facc_r  <= {FRAC_W{1'b0}};
      phase_r <= {PH_W{1'b0}};
    end else begin
      cnt_r   <= cnt_d;
      facc_r  <= facc_d;
      phase_r <= phase_d;
    end
  end
endmodule

// File: rtl/uart_baud_gen.sv
// Dual-channel (RX/TX) oversampling baud tick generator sharing one
// runtime-programmable integer+fractional divisor.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_HZ      = 25000000,
  parameter int BAUD_RATE   = 9600,
  parameter int SAMPLE_RATE = 16,
  parameter int DIV_W       = DIV_W_DEF,
  parameter int FRAC_W      = FRAC_W_DEF
) (
  input  logic          clock,
  input  logic          reset,
  uart_baud_gen_if.slave bus
);
  localparam baud_div_t RST_DIV = reset_div(longint'(CLK_HZ), longint'(BAUD_RATE),
                                            longint'(SAMPLE_RATE), FRAC_W);
  localparam logic [DIV_W-1:0]  RESET_DIV_INT  = RST_DIV.div_int[DIV_W-1:0];
  localparam logic [FRAC_W-1:0] RESET_DIV_FRAC = RST_DIV.div_frac[FRAC_W-1:0];
  localparam logic [DIV_W-1:0]  RESET_CNT      = RESET_DIV_INT - DIV_W'(1);

  logic [DIV_W-1:0]  div_i_q;
  logic [FRAC_W-1:0] div_f_q;
  logic [DIV_W-1:0]  div_int_clamp_s;
  logic              unused_tx_sample_s;

  // Periods shorter than two cycles would leave the counter no reload slot.
  always_comb begin
    div_int_clamp_s = bus.div_int;
    if (bus.div_int < DIV_W'(2)) begin
      div_int_clamp_s = DIV_W'(2);
    end else begin
      div_int_clamp_s = bus.div_int;
    end
  end

  // Shared divisor registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_i_q <= RESET_DIV_INT;
      div_f_q <= RESET_DIV_FRAC;
    end else if (bus.div_load) begin
      div_i_q <= div_int_clamp_s;
      div_f_q <= bus.div_frac;
    end else begin
      div_i_q <= div_i_q;
      div_f_q <= div_f_q;
    end
  end

  baud_channel #(
    .SAMPLE_RATE(SAMPLE_RATE), .DIV_W(DIV_W), .FRAC_W(FRAC_W),
    .HALF_START(1), .RESET_CNT(RESET_CNT)
  ) u_rx (
    .clock(clock), .reset(reset), .div_i(div_i_q), .div_f(div_f_q),
    .start(bus.rx_start), .tick(bus.rx_tick), .sample(bus.rx_sample),
    .bit_strobe(bus.rx_bit)
  );

  baud_channel #(
    .SAMPLE_RATE(SAMPLE_RATE), .DIV_W(DIV_W), .FRAC_W(FRAC_W),
    .HALF_START(0), .RESET_CNT(RESET_CNT)
  ) u_tx (
    .clock(clock), .reset(reset), .div_i(div_i_q), .div_f(div_f_q),
    .start(bus.tx_start), .tick(bus.tx_tick), .sample(unused_tx_sample_s),
    .bit_strobe(bus.tx_bit)
  );
endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen: directed scenarios plus random
// divisor/resync traffic against a tick-time-level reference model.
module tb_uart_baud_gen;
  localparam int R_INT  = 25000000 / (9600 * 16);
  localparam int R_FRAC = ((25000000 * 16) / (9600 * 16)) % 16;
  localparam int SR     = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  uart_baud_gen_if bus ();

  uart_baud_gen dut (.clock(clock), .reset(reset), .bus(bus.slave));

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int t;
  int m_nt[2], m_facc[2], m_phase[2];
  int m_di, m_df;
  int rx_times[$], tx_times[$], rxs_times[$], rxb_times[$], txb_times[$];
  int ts;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed=%0d expected=%0d (t=%0d)", tag, obs, exp, t);
      $error("%s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int span(input int q[$], input int i, input int j);
    if (q.size() > j) return q[j] - q[i];
    return -1;
  endfunction

  function automatic int first(input int q[$]);
    if (q.size() > 0) return q[0];
    return -1;
  endfunction

  task automatic model_reset();
    t    = 0;
    m_di = R_INT;
    m_df = R_FRAC;
    for (int c = 0; c < 2; c++) begin
      m_nt[c] = R_INT - 1; m_facc[c] = 0; m_phase[c] = 0;
    end
  endtask

  task automatic clear_q();
    rx_times.delete(); tx_times.delete(); rxs_times.delete();
    rxb_times.delete(); txb_times.delete();
  endtask

  task automatic idle_inputs();
    bus.div_load = 1'b0; bus.rx_start = 1'b0; bus.tx_start = 1'b0;
  endtask

  // Compare this cycle's strobes, clock once, advance the model.
  task automatic step();
    logic tk[2];
    logic st[2];
    logic ld;
    int   din, dfr, s;
    for (int c = 0; c < 2; c++) tk[c] = (t == m_nt[c]);
    chk("rx_tick",   bus.rx_tick,   tk[0]);
    chk("rx_sample", bus.rx_sample, tk[0] && m_phase[0] == SR / 2 - 1);
    chk("rx_bit",    bus.rx_bit,    tk[0] && m_phase[0] == SR - 1);
    chk("tx_tick",   bus.tx_tick,   tk[1]);
    chk("tx_bit",    bus.tx_bit,    tk[1] && m_phase[1] == SR - 1);
    if (bus.rx_tick === 1'b1)   rx_times.push_back(t);
    if (bus.tx_tick === 1'b1)   tx_times.push_back(t);
    if (bus.rx_sample === 1'b1) rxs_times.push_back(t);
    if (bus.rx_bit === 1'b1)    rxb_times.push_back(t);
    if (bus.tx_bit === 1'b1)    txb_times.push_back(t);
    st[0] = bus.rx_start; st[1] = bus.tx_start; ld = bus.div_load;
    din = int'(bus.div_int); dfr = int'(bus.div_frac);
    @(posedge clock);
    for (int c = 0; c < 2; c++) begin
      if (st[c]) begin
        m_nt[c] = t + 1 + ((c == 0) ? m_di / 2 : m_di - 1);
        m_facc[c] = 0; m_phase[c] = 0;
      end else if (tk[c]) begin
        s = m_facc[c] + m_df;
        m_facc[c]  = s % 16;
        m_nt[c]    = t + m_di + ((s >= 16) ? 1 : 0);
        m_phase[c] = (m_phase[c] + 1) % SR;
      end
    end
    if (ld) begin
      m_di = (din < 2) ? 2 : din;
      m_df = dfr;
    end
    #1;
    t++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load(input int di, input int df);
    bus.div_int = 16'(di); bus.div_frac = 4'(df); bus.div_load = 1'b1;
    step();
    bus.div_load = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rx_tick"}, bus.rx_tick, 1'b0);
    chk({tag, "_rx_sample"}, bus.rx_sample, 1'b0);
    chk({tag, "_rx_bit"}, bus.rx_bit, 1'b0);
    chk({tag, "_tx_tick"}, bus.tx_tick, 1'b0);
    chk({tag, "_tx_bit"}, bus.tx_bit, 1'b0);
  endtask

  initial begin
    t = 0;
    bus.div_int = 16'd0; bus.div_frac = 4'd0;
    idle_inputs();
    #12;
    chk_quiet("in_reset");
    #15;
    reset = 1'b0;
    model_reset();

    // Integer divisor 4 on both channels.
    load(4, 0);
    bus.rx_start = 1'b1; bus.tx_start = 1'b1;
    step();
    idle_inputs();
    clear_q();
    run(140);
    chk("div4_rx_period", span(rx_times, 0, 1), 4);
    chk("div4_tx_period", span(tx_times, 2, 3), 4);
    chk("div4_txbit_period", span(txb_times, 0, 1), 64);

    // Fractional 4 + 8/16: periods alternate 4,5.
    load(4, 8);
    bus.tx_start = 1'b1;
    step();
    idle_inputs();
    clear_q();
    run(40);
    chk("frac_span_1_5", span(tx_times, 0, 4), 18);
    chk("frac_p1", span(tx_times, 0, 1), 4);
    chk("frac_p2", span(tx_times, 1, 2), 5);

    // RX resync with divisor 10.
    load(10, 0);
    bus.rx_start = 1'b1; ts = t;
    step();
    idle_inputs();
    clear_q();
    run(170);
    chk("rx_first_tick", first(rx_times) - (ts + 1), 5);
    chk("rx_first_sample", first(rxs_times) - (ts + 1), 75);
    chk("rx_first_bit", first(rxb_times) - (ts + 1), 155);

    // Resync landing on an rx tick.
    for (int i = 0; i < 20; i++) begin
      if (t == m_nt[0]) break;
      step();
    end
    chk("coincide_found", (t == m_nt[0]), 1'b1);
    chk("coincide_tick_visible", bus.rx_tick, 1'b1);
    bus.rx_start = 1'b1; ts = t;
    step();
    idle_inputs();
    clear_q();
    run(200);
    chk("coincide_next_tick", first(rx_times) - (ts + 1), 5);
    chk("coincide_period", span(rx_times, 0, 1), 10);
    chk("coincide_sample", first(rxs_times) - (ts + 1), 75);

    // Clamp to 2, then reprogram mid-period.
    load(1, 0);
    bus.rx_start = 1'b1; bus.tx_start = 1'b1;
    step();
    idle_inputs();
    clear_q();
    run(10);
    chk("clamp_period", span(tx_times, 0, 1), 2);
    if (t == m_nt[1]) step();
    ts = t;
    clear_q();
    load(8, 0);
    run(30);
    chk("midload_cur_period", first(tx_times), ts + 1);
    chk("midload_next_period", span(tx_times, 0, 1), 8);

    // Random divisor loads and resyncs.
    for (int i = 0; i < 1500; i++) begin
      bus.div_load = ($urandom_range(0, 39) == 0);
      bus.div_int  = 16'($urandom_range(0, 12));
      bus.div_frac = 4'($urandom_range(0, 15));
      bus.rx_start = ($urandom_range(0, 59) == 0);
      bus.tx_start = ($urandom_range(0, 59) == 0);
      step();
    end
    idle_inputs();

    // Asynchronous reset mid-stream, then default divisor.
    reset = 1'b1;
    #1;
    chk_quiet("async_reset");
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      chk_quiet("held_reset");
    end
    reset = 1'b0;
    model_reset();
    clear_q();
    run(161 + 64 * 163 + 4);
    chk("post_reset_first_rx", first(rx_times), 161);
    chk("post_reset_first_tx", first(tx_times), 161);
    chk("avg_period_64", span(tx_times, 0, 64), 10416);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_baud_gen.md
Name: uart_baud_gen

Overview:
Dual-channel oversampling baud tick generator for the UART, with a runtime-programmable divisor that has a fractional part. It produces independent RX and TX tick streams at SAMPLE_RATE x baud. Each channel has its own resync input and a phase counter. It emits a mid-bit sample strobe for the RX deserialiser and bit-boundary strobes for both the RX and TX shifters.

Parameters:
CLK_HZ, 25000000, input clock frequency; used only for reset divisor values.
BAUD_RATE, 9600, baud rate selected at reset.
SAMPLE_RATE, 16, ticks per bit; power of two, >= 4.
DIV_W, 16, width of the integer divisor.
FRAC_W, 4, width of the fractional divisor (units of 1/2^FRAC_W cycle).
RESET_DIV_INT, CLK_HZ/(BAUD_RATE*SAMPLE_RATE), integer divisor after reset (162 at defaults).
RESET_DIV_FRAC, ((CLK_HZ*2^FRAC_W)/(BAUD_RATE*SAMPLE_RATE)) mod 2^FRAC_W, fractional divisor after reset (12 at defaults).

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high
div_int  input  DIV_W  new integer divisor (cycles per tick)
div_frac  input  FRAC_W  new fractional divisor
div_load  input  1  one-cycle strobe; latch div_int/div_frac
rx_start  input  1  resync RX channel to half a tick period (start-bit edge)
tx_start  input  1  resync TX channel to a full tick period
rx_tick  output  1  RX oversample tick, one-cycle pulse
rx_sample  output  1  RX mid-bit strobe (subset of rx_tick)
rx_bit  output  1  RX end-of-bit strobe (subset of rx_tick)
tx_tick  output  1  TX oversample tick
tx_bit  output  1  TX end-of-bit strobe (subset of tx_tick)

Behaviour:
- Divisor registers div_i_q and div_f_q are shared by both channels.
  - Reset loads RESET_DIV_INT and RESET_DIV_FRAC.
  - div_load writes them on the next edge.
  - A div_int value below 2 is stored as 2.
- Each channel has:
  - cnt (DIV_W bits), a down-counter;
  - facc (FRAC_W bits), the fractional accumulator;
  - phase (log2(SAMPLE_RATE) bits).
- tick = (cnt == 0). It is decoded from registered state only, with no combinational path from any input.
- Reload on tick: sum = facc + div_f_q, computed FRAC_W+1 bits wide. facc <= sum[FRAC_W-1:0].
  - If sum carries, cnt <= div_i_q, giving a period of div_i_q+1.
  - Otherwise cnt <= div_i_q-1, giving a period of div_i_q.
  - Long-run average period = div_i_q + div_f_q/2^FRAC_W cycles.
- Otherwise cnt <= cnt-1 each cycle.
- phase increments on every tick and wraps from SAMPLE_RATE-1 to 0.
- RX strobes:
  - rx_sample = rx_tick & (rx_phase == SAMPLE_RATE/2-1).
  - rx_bit = rx_tick & (rx_phase == SAMPLE_RATE-1).
- TX strobe: tx_bit = tx_tick & (tx_phase == SAMPLE_RATE-1).
- rx_start (priority over the reload): rx cnt <= div_i_q>>1, facc <= 0, phase <= 0. The first rx_tick comes (div_i_q>>1) cycles after the sampling edge.
- tx_start: tx cnt <= div_i_q-1, facc <= 0, phase <= 0. The first tx_tick comes div_i_q-1 cycles after the sampling edge.
- Start coincident with tick: the tick pulse is still output that cycle, because it comes from registered state. The start assignments win, so phase is not advanced.
- div_load during a period: the period already in progress is not altered. The new divisor takes effect at the next reload or start.
- div_load coincident with reload or start: the reload or start uses the old divisor; the new divisor applies from the following reload.
- rx_start and tx_start are independent. Asserting both in the same cycle resyncs both channels.
- Reset values:
  - all outputs 0;
  - phases 0, facc 0;
  - cnt = RESET_DIV_INT-1 in both channels, so the first ticks occur RESET_DIV_INT-1 cycles after reset release.
- Reset mid-operation restores these values immediately (asynchronous); no strobe occurs while reset is high.
- Channels free-run; there is no enable input.

Decomposition:
- Package uart_pkg holds:
  - the DIV_W and FRAC_W defaults;
  - a reset-divisor function computing RESET_DIV_INT and RESET_DIV_FRAC from CLK_HZ, BAUD_RATE and SAMPLE_RATE;
  - the baud_div_t struct {int, frac}.
- Sub-module baud_channel holds one channel's cnt/facc/phase and its strobe decode. It has parameter HALF_START (1 for RX, 0 for TX) and is instantiated twice.
- The top level holds the divisor registers and the clamp.

Test Plan:
- Reset, then div_load 4/0 -> rx_tick and tx_tick pulse every 4 cycles; tx_bit every 64 cycles.
- div_load 4/8 (FRAC_W=4) -> tick periods alternate 4,5; exactly 18 cycles between tick 1 and tick 5.
- div 10/0, rx_start -> rx_tick at +5 cycles, then every 10 cycles; rx_sample at +75, rx_bit at +155 cycles; tx_tick timing unaffected.
- rx_start asserted in a cycle where rx_tick=1 -> tick visible that cycle, rx_phase 0 afterwards, next rx_tick 5 cycles later (div 10).
- div_load 1/0 -> stored as 2, tick every 2 cycles; then div_load 8/0 mid-period -> current period unchanged, following periods 8.
- Assert reset mid-stream -> all strobes 0 immediately; after release, defaults 162/12: first tick at 161 cycles, average period 162.75 over 64 ticks.
